dino_game_top: RTL and testbench

- Top-level of a minimal side-scrolling "dino" game on a 2-row × 8-column bit grid.
- Obstacles scroll leftward along the ground row. The player pulses jmp to lift the dino into the upper row for a fixed number of game steps.
- A collision latches game_over and freezes the display.
- Sits between a button/debounce front end and an LED or 2×8 display driver.

---
 rtl/dino_pkg.sv | 17 +
 rtl/dino_game_lfsr.sv | 21 ++
 rtl/dino_game_top.sv | 103 ++++++++++
 tb/tb_dino_game_top.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and constants for the 2x8 dino game.
package dino_pkg;

  localparam int unsigned ROW_W = 8;

  // Feedback taps for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3).
  localparam logic [ROW_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    AIRBORNE = 2'd1,
    OVER     = 2'd2
  } dino_state_t;

endpackage

// File: rtl/dino_game_lfsr.sv
// 8-bit Fibonacci LFSR shifting toward the MSB; advances once per enable.
import dino_pkg::*;

module dino_lfsr #(
  parameter logic [ROW_W-1:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output row_t state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[ROW_W-2:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/dino_game_top.sv
// Dino game core: tick divider, jump FSM, obstacle shifter and collision latch.
import dino_pkg::*;

module dino_game_top #(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned JUMP_TICKS = 3,
  parameter int unsigned DINO_COL   = 6,
  parameter int unsigned MIN_GAP    = 4,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jmp,
  output logic [15:0] grid_out,
  output logic        game_over
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned JW = $clog2(JUMP_TICKS + 1);
  localparam int unsigned GW = $clog2(MIN_GAP + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam row_t DINO_BIT = row_t'(1) << DINO_COL;

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [TW-1:0] tick;
  logic [JW-1:0] jcnt, jcnt_nxt;
  logic [GW-1:0] gap;
  row_t          obst, obst_nxt, lfsr;
  dino_state_t   state;
  logic          jump_req, step, spawn, air_nxt, takeoff, hit;
  logic          lfsr_unused;

  // Assert asynchronously, release two clocks later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  dino_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (step),
    .state (lfsr)
  );
  assign lfsr_unused = ^lfsr[ROW_W-1:1];

  assign step     = (state != OVER) && (tick == TICK_LAST);
  assign spawn    = lfsr[0] && (gap >= GW'(MIN_GAP));
  assign obst_nxt = {obst[ROW_W-2:0], spawn};

  always_comb begin
    air_nxt  = 1'b0;
    jcnt_nxt = jcnt;
    takeoff  = 1'b0;
    if (state == AIRBORNE) begin
      jcnt_nxt = jcnt - JW'(1);
      air_nxt  = (jcnt_nxt != '0);
    end else if (jump_req) begin
      jcnt_nxt = JW'(JUMP_TICKS);
      air_nxt  = 1'b1;
      takeoff  = 1'b1;
    end
  end

  assign hit = !air_nxt && obst_nxt[DINO_COL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick      <= '0;
      obst      <= '0;
      gap       <= GW'(MIN_GAP);
      state     <= GROUNDED;
      jcnt      <= '0;
      jump_req  <= 1'b0;
      game_over <= 1'b0;
      grid_out  <= {8'h00, DINO_BIT};
    end else if (state != OVER) begin
      tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
      // A takeoff consumes the request; otherwise any grounded jmp arms it.
      if (step && takeoff)
        jump_req <= 1'b0;
      else if (state == GROUNDED && jmp)
        jump_req <= 1'b1;
      if (step) begin
        obst <= obst_nxt;
        jcnt <= jcnt_nxt;
        if (spawn)                    gap <= '0;
        else if (gap < GW'(MIN_GAP))  gap <= gap + GW'(1);
        if (hit) begin
          state     <= OVER;
          game_over <= 1'b1;
        end else begin
          state <= air_nxt ? AIRBORNE : GROUNDED;
        end
        grid_out <= {(air_nxt ? DINO_BIT : row_t'(0)),
                     obst_nxt | (air_nxt ? row_t'(0) : DINO_BIT)};
      end
    end
  end

endmodule

// File: tb/tb_dino_game_top.sv
// Scoreboard bench: stimulus queues expected frames, a monitor checks each displayed change.
module tb_dino_game_top;

  typedef struct {
    logic [16:0] val;   // {game_over, grid_out}
    int          gap;   // expected cycles since previous change, 0 = don't care
  } exp_t;

  logic        clk, reset, jmp;
  logic [15:0] grid_out;
  logic        game_over;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 0;

  dino_game_top #(
    .TICK_DIV   (4),
    .JUMP_TICKS (3),
    .DINO_COL   (6),
    .MIN_GAP    (4),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .jmp       (jmp),
    .grid_out  (grid_out),
    .game_over (game_over)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every change of the displayed frame pops and checks one expectation.
  initial begin
    logic [16:0] cur, prev;
    int last_cyc;
    exp_t e;
    prev = '0;
    last_cyc = 0;
    forever begin
      @(negedge clk);
      cur = {game_over, grid_out};
      if (mon_en && cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame got=%h cycle=%0d", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.val || (e.gap != 0 && (cyc - last_cyc) != e.gap)) begin
            failures++;
            $display("FAIL frame got=%h gap=%0d want=%h gap=%0d",
                     cur, cyc - last_cyc, e.val, e.gap);
          end
        end
        last_cyc = cyc;
      end
      prev = cur;
    end
  end

  task automatic push(input logic [16:0] v, input int g);
    exp_t e;
    e.val = v;
    e.gap = g;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_frame(input logic [16:0] v, input int limit);
    int n = 0;
    while ({game_over, grid_out} !== v && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      failures++;
      $display("FAIL wait_frame got=%h want=%h (timeout)", {game_over, grid_out}, v);
    end
  endtask

  task automatic pulse_jmp();
    jmp = 1;
    @(negedge clk);
    @(negedge clk);
    jmp = 0;
  endtask

  // Spawns happen at steps 1, 6, 11 (LFSR lsb 1 with gap satisfied).
  initial begin
    reset = 1;
    jmp   = 0;
    #1 reset = 0;
    repeat (3) @(negedge clk);
    check("reset_grid", {1'b0, grid_out}, 17'h0_0040);
    check("reset_over", {16'h0, game_over}, 17'h0);

    // Run 1: jump at step 6 clears obstacle 1, air jump ignored, collide at step 12.
    push(17'h0_0041, 0);
    push(17'h0_0042, 4);
    push(17'h0_0044, 4);
    push(17'h0_0048, 4);
    push(17'h0_0050, 4);
    push(17'h0_4021, 4);
    push(17'h0_4042, 4);
    push(17'h0_4084, 4);
    push(17'h0_0048, 4);
    push(17'h0_0050, 4);
    push(17'h0_0061, 4);
    push(17'h1_0042, 4);
    mon_en = 1;
    reset  = 1;

    wait_frame(17'h0_0050, 200);
    pulse_jmp();
    wait_frame(17'h0_4042, 200);
    pulse_jmp();
    wait_frame(17'h1_0042, 200);

    // Frozen after collision; jmp pulses must not disturb anything.
    for (int i = 0; i < 24; i++) begin
      jmp = ((i % 5) < 2);
      @(negedge clk);
    end
    jmp = 0;
    check("frozen_frame", {game_over, grid_out}, 17'h1_0042);

    // Mid-game reset, then an un-jumped replay colliding at step 7.
    push(17'h0_0040, 0);
    push(17'h0_0041, 0);
    push(17'h0_0042, 4);
    push(17'h0_0044, 4);
    push(17'h0_0048, 4);
    push(17'h0_0050, 4);
    push(17'h0_0061, 4);
    push(17'h1_0042, 4);
    reset = 0;
    #1;
    check("async_reset", {game_over, grid_out}, 17'h0_0040);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    wait_frame(17'h1_0042, 200);
    repeat (8) @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
